// File: rtl/uart_pkg.sv
// Constants shared between the UART byte-sequence generator and its receive-side checker.
package uart_pkg;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    localparam int CLK_HZ = 50000000;

    // The transmit driver advances by this step every byte, wrapping modulo 256.
    localparam logic [7:0] SEQ_INC = 8'd1;

endpackage

// File: rtl/uart_rx_seq_checker_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over a same-cycle increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != '1)) begin
            q_d = q_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/uart_rx_seq_checker.sv
// Locks onto the incrementing-byte stream from the UART receiver and keeps good/error statistics.
//   state     | meaning
//   ST_HUNT   | waiting for any byte to use as the sync point
//   ST_LOCKED | checking each byte against expected, watching for silence
module uart_rx_seq_checker
    import uart_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter int LOSS_THRESH    = 4,
    parameter int TIMEOUT_CYCLES = CLK_HZ,
    parameter int TO_W           = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_dv,
    input  logic [7:0]       rx_byte,
    input  logic             clr_stats,
    output logic             locked,
    output logic [7:0]       expected,
    output logic             err_pulse,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             timeout,
    output logic             lost_lock
);

    // Idle timer counts down from here; reaching zero on an idle cycle is the
    // TIMEOUT_CYCLES-1'th idle cycle since the last byte.
    localparam logic [TO_W-1:0] IDLE_LOAD = TO_W'(TIMEOUT_CYCLES - 2);
    localparam logic [3:0]      MISS_MAX  = 4'(LOSS_THRESH);

    state_e          state_q, state_d;
    logic [7:0]      exp_q, exp_d;
    logic [3:0]      miss_q, miss_d;
    logic [TO_W-1:0] idle_q, idle_d;
    logic            err_pulse_q, err_pulse_d;
    logic            timeout_q, timeout_d;
    logic            lost_q, lost_d;
    logic            good_inc;
    logic            err_inc;

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        miss_d      = miss_q;
        idle_d      = idle_q;
        err_pulse_d = 1'b0;
        timeout_d   = timeout_q;
        lost_d      = lost_q;
        good_inc    = 1'b0;
        err_inc     = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (rx_dv) begin
                    exp_d   = rx_byte + SEQ_INC;
                    miss_d  = '0;
                    idle_d  = IDLE_LOAD;
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (rx_dv) begin
                    exp_d  = exp_q + SEQ_INC;
                    idle_d = IDLE_LOAD;
                    if (rx_byte == exp_q) begin
                        good_inc = 1'b1;
                        miss_d   = '0;
                    end else begin
                        err_inc     = 1'b1;
                        err_pulse_d = 1'b1;
                        miss_d      = miss_q + 4'd1;
                        if (miss_d == MISS_MAX) begin
                            lost_d  = 1'b1;
                            state_d = ST_HUNT;
                        end
                    end
                end else if (idle_q == '0) begin
                    timeout_d = 1'b1;
                    state_d   = ST_HUNT;
                end else begin
                    idle_d = idle_q - 1'b1;
                end
            end
            default: state_d = ST_HUNT;
        endcase

        if (clr_stats) begin
            timeout_d = 1'b0;
            lost_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HUNT;
            exp_q       <= '0;
            miss_q      <= '0;
            idle_q      <= '0;
            err_pulse_q <= 1'b0;
            timeout_q   <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            miss_q      <= miss_d;
            idle_q      <= idle_d;
            err_pulse_q <= err_pulse_d;
            timeout_q   <= timeout_d;
            lost_q      <= lost_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_good_cnt (
        .clk (clk),
        .rst (rst),
        .inc (good_inc),
        .clr (clr_stats),
        .q   (good_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (err_inc),
        .clr (clr_stats),
        .q   (err_cnt)
    );

    assign locked    = (state_q == ST_LOCKED);
    assign expected  = exp_q;
    assign err_pulse = err_pulse_q;
    assign timeout   = timeout_q;
    assign lost_lock = lost_q;

endmodule

// File: tb/tb_uart_rx_seq_checker.sv
// Bench for uart_rx_seq_checker: vector table plus a reference-model scoreboard.
module tb_uart_rx_seq_checker;

    localparam int CNT_W = 4;
    localparam int LT    = 4;
    localparam int TO    = 100;
    localparam int TO_W  = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             rx_dv = 1'b0;
    logic [7:0]       rx_byte = 8'h00;
    logic             clr_stats = 1'b0;
    logic             locked;
    logic [7:0]       expected;
    logic             err_pulse;
    logic [CNT_W-1:0] good_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             timeout;
    logic             lost_lock;

    uart_rx_seq_checker #(
        .CNT_W(CNT_W), .LOSS_THRESH(LT), .TIMEOUT_CYCLES(TO), .TO_W(TO_W)
    ) dut (
        .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_byte(rx_byte), .clr_stats(clr_stats),
        .locked(locked), .expected(expected), .err_pulse(err_pulse),
        .good_cnt(good_cnt), .err_cnt(err_cnt), .timeout(timeout), .lost_lock(lost_lock)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             lk;
        logic [7:0]       ex;
        logic             ep;
        logic [CNT_W-1:0] gd;
        logic [CNT_W-1:0] er;
        logic             to;
        logic             ll;
    } obs_t;

    typedef struct {
        logic       r;
        logic       dv;
        logic [7:0] b;
        logic       clr;
        obs_t       want;
    } vec_t;

    obs_t dut_obs;
    assign dut_obs = {locked, expected, err_pulse, good_cnt, err_cnt, timeout, lost_lock};

    obs_t sb_q[$];
    vec_t tbl[23];
    int   n_vec = 0;
    int   n_bad = 0;

    logic             m_lk = 1'b0;
    logic [7:0]       m_ex = 8'h00;
    logic             m_ep = 1'b0;
    logic [CNT_W-1:0] m_gd = '0;
    logic [CNT_W-1:0] m_er = '0;
    logic             m_to = 1'b0;
    logic             m_ll = 1'b0;
    int               m_miss = 0;
    int               m_idle = 0;

    function automatic vec_t mk(logic r, logic dv, logic [7:0] b, logic clr,
                                logic lk, logic [7:0] ex, logic ep, int gd, int er,
                                logic to, logic ll);
        vec_t v;
        v.r = r; v.dv = dv; v.b = b; v.clr = clr;
        v.want = {lk, ex, ep, CNT_W'(gd), CNT_W'(er), to, ll};
        return v;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    // Reference behaviour, written against the idle count as an up-counter to TO-1.
    task automatic model(logic r, logic dv, logic [7:0] b, logic clr);
        logic g_inc, e_inc, to_set, ll_set;
        g_inc = 1'b0; e_inc = 1'b0; to_set = 1'b0; ll_set = 1'b0;
        if (r) begin
            m_lk = 0; m_ex = 0; m_ep = 0; m_gd = 0; m_er = 0; m_to = 0; m_ll = 0;
            m_miss = 0; m_idle = 0;
            return;
        end
        m_ep = 1'b0;
        if (!m_lk) begin
            if (dv) begin
                m_ex = b + 8'd1; m_lk = 1'b1; m_miss = 0; m_idle = 0;
            end
        end else if (dv) begin
            m_idle = 0;
            if (b == m_ex) begin
                g_inc = 1'b1; m_miss = 0;
            end else begin
                e_inc = 1'b1; m_ep = 1'b1; m_miss++;
                if (m_miss == LT) begin
                    ll_set = 1'b1; m_lk = 1'b0;
                end
            end
            m_ex = m_ex + 8'd1;
        end else begin
            m_idle++;
            if (m_idle == TO - 1) begin
                to_set = 1'b1; m_lk = 1'b0; m_idle = 0;
            end
        end
        if (clr) begin
            m_gd = '0; m_er = '0; m_to = 1'b0; m_ll = 1'b0;
        end else begin
            if (g_inc && m_gd != {CNT_W{1'b1}}) m_gd = m_gd + CNT_W'(1);
            if (e_inc && m_er != {CNT_W{1'b1}}) m_er = m_er + CNT_W'(1);
            m_to = m_to | to_set;
            m_ll = m_ll | ll_set;
        end
    endtask

    task automatic step(logic r, logic dv, logic [7:0] b, logic clr);
        obs_t w;
        @(negedge clk);
        rst = r; rx_dv = dv; rx_byte = b; clr_stats = clr;
        model(r, dv, b, clr);
        sb_q.push_back({m_lk, m_ex, m_ep, m_gd, m_er, m_to, m_ll});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL scoreboard: queue empty, required one entry");
        end else begin
            w = sb_q.pop_front();
            check("scoreboard", 32'(dut_obs), 32'(w));
        end
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        //                r  dv  byte   clr  lk ex     ep gd er to ll
        tbl[0]  = mk(1, 0, 8'h00, 0,  0, 8'h00, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 8'h05, 0,  1, 8'h06, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 8'h06, 0,  1, 8'h07, 0, 1, 0, 0, 0);
        tbl[3]  = mk(0, 1, 8'h07, 0,  1, 8'h08, 0, 2, 0, 0, 0);
        tbl[4]  = mk(1, 0, 8'h00, 0,  0, 8'h00, 0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 1, 8'hFE, 0,  1, 8'hFF, 0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 1, 8'hFF, 0,  1, 8'h00, 0, 1, 0, 0, 0);
        tbl[7]  = mk(0, 1, 8'h00, 0,  1, 8'h01, 0, 2, 0, 0, 0);
        tbl[8]  = mk(0, 1, 8'h01, 0,  1, 8'h02, 0, 3, 0, 0, 0);
        tbl[9]  = mk(1, 0, 8'h00, 0,  0, 8'h00, 0, 0, 0, 0, 0);
        tbl[10] = mk(0, 1, 8'h0F, 0,  1, 8'h10, 0, 0, 0, 0, 0);
        tbl[11] = mk(0, 1, 8'h10, 0,  1, 8'h11, 0, 1, 0, 0, 0);
        tbl[12] = mk(0, 1, 8'hAA, 0,  1, 8'h12, 1, 1, 1, 0, 0);
        tbl[13] = mk(0, 1, 8'h12, 0,  1, 8'h13, 0, 2, 1, 0, 0);
        tbl[14] = mk(0, 1, 8'h13, 1,  1, 8'h14, 0, 0, 0, 0, 0);
        tbl[15] = mk(0, 1, 8'h00, 0,  1, 8'h15, 1, 0, 1, 0, 0);
        tbl[16] = mk(0, 1, 8'h00, 0,  1, 8'h16, 1, 0, 2, 0, 0);
        tbl[17] = mk(0, 1, 8'h00, 0,  1, 8'h17, 1, 0, 3, 0, 0);
        tbl[18] = mk(0, 1, 8'h00, 0,  0, 8'h18, 1, 0, 4, 0, 1);
        tbl[19] = mk(0, 1, 8'h30, 0,  1, 8'h31, 0, 0, 4, 0, 1);
        tbl[20] = mk(0, 0, 8'h00, 0,  1, 8'h31, 0, 0, 4, 0, 1);
        tbl[21] = mk(0, 0, 8'h00, 1,  1, 8'h31, 0, 0, 0, 0, 0);
        tbl[22] = mk(0, 1, 8'h31, 0,  1, 8'h32, 0, 1, 0, 0, 0);

        for (int i = 0; i < 23; i++) begin
            step(tbl[i].r, tbl[i].dv, tbl[i].b, tbl[i].clr);
            check($sformatf("table[%0d]", i), 32'(dut_obs), 32'(tbl[i].want));
        end

        // Idle timeout fires on the 99th silent cycle, not before.
        idle(98);
        check("idle98_lk_to", {30'd0, locked, timeout}, 32'b10);
        idle(1);
        check("idle99_lk_to", {30'd0, locked, timeout}, 32'b01);

        // A byte landing on the terminal idle cycle wins over the timeout.
        step(1'b0, 1'b1, 8'h50, 1'b1);
        check("relock_clr", {22'd0, locked, timeout, expected}, {22'd0, 2'b10, 8'h51});
        idle(98);
        step(1'b0, 1'b1, 8'h51, 1'b0);
        check("dv_on_99", {22'd0, locked, timeout, 4'(good_cnt), 4'd0},
              {22'd0, 2'b10, 4'd1, 4'd0});
        idle(98);
        check("idle_restart", {30'd0, locked, timeout}, 32'b10);

        // Statistics saturate instead of wrapping.
        for (int k = 0; k < 20; k++) step(1'b0, 1'b1, 8'h52 + 8'(k), 1'b0);
        check("good_sat", 32'(good_cnt), 32'(4'hF));
        step(1'b0, 1'b1, 8'h00, 1'b0);
        check("good_hold_err1", {24'd0, 4'(good_cnt), 4'(err_cnt)}, {24'd0, 4'hF, 4'h1});

        // Reset mid-stream, even with a byte strobed, discards everything.
        step(1'b1, 1'b1, 8'h67, 1'b0);
        check("rst_mid", 32'(dut_obs), 32'd0);
        step(1'b0, 1'b1, 8'h77, 0);
        check("post_rst_lock", {23'd0, locked, expected}, {23'd0, 1'b1, 8'h78});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

// File: doc/uart_rx_seq_checker.md
Name: uart_rx_seq_checker

Overview:
Receive-side companion to the UART byte-sequence generator. It consumes bytes delivered by the UART receiver, locks onto the incrementing-byte pattern the transmit driver produces (modulo 256), and counts good and bad bytes. It also flags loss of lock and line silence. It sits between the UART RX core and the DE10 status LEDs/7-segment display.

Parameters:
CNT_W, 16, width of the good/error statistics counters
LOSS_THRESH, 4, consecutive mismatches in LOCKED that force return to HUNT (range 1..15)
TIMEOUT_CYCLES, 50000000, idle clk cycles in LOCKED with no byte before timeout (1 s at 50 MHz)
TO_W, 26, width of the idle counter; must satisfy 2^TO_W > TIMEOUT_CYCLES

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
rx_dv  in  1  one-cycle strobe: rx_byte is valid
rx_byte  in  8  received byte
clr_stats  in  1  synchronous clear of counters and sticky flags
locked  out  1  1 while the FSM is in LOCKED
expected  out  8  next byte value expected
err_pulse  out  1  one-cycle pulse on each mismatch
good_cnt  out  CNT_W  matching bytes, saturating
err_cnt  out  CNT_W  mismatching bytes, saturating
timeout  out  1  sticky: idle timeout occurred
lost_lock  out  1  sticky: LOSS_THRESH consecutive mismatches occurred

Behaviour:
- Reset (rst high at a clk edge): state=HUNT. locked=0, expected=0, err_pulse=0, good_cnt=0, err_cnt=0, timeout=0, lost_lock=0. Miss run and idle counters are cleared. Reset mid-byte discards all history.
- All outputs are registered. Effects of an rx_dv appear on the cycle after the strobe edge.
- HUNT state:
  - rx_dv=1: expected<=rx_byte+1 (8-bit wrap, so 0xFF→0x00). Go to LOCKED. Clear miss run and idle counter.
  - The sync byte is not counted as good or bad.
  - No timeout while in HUNT.
- LOCKED state, rx_dv=1 and rx_byte==expected:
  - good_cnt+1; miss run<=0; expected<=expected+1; idle counter<=0.
- LOCKED state, rx_dv=1 and rx_byte!=expected:
  - err_cnt+1; err_pulse=1 for one cycle; miss run+1.
  - expected<=expected+1. The expected value does not resync to the bad byte, so a single corrupted byte costs exactly one error.
  - idle counter<=0.
  - If the miss run reaches LOSS_THRESH: lost_lock<=1, go to HUNT.
- LOCKED state, rx_dv=0:
  - idle counter+1.
  - When it reaches TIMEOUT_CYCLES-1: timeout<=1, go to HUNT, idle counter<=0.
  - If rx_dv and the terminal idle count occur in the same cycle, rx_dv wins: the byte is processed and there is no timeout.
- Counters saturate at all-ones; they never wrap.
- clr_stats=1:
  - good_cnt, err_cnt, timeout and lost_lock are cleared. The clear has priority over any same-cycle increment or set.
  - FSM state, expected and the miss run are unaffected. A same-cycle rx_dv still advances expected and the FSM.
- err_pulse is 0 on every cycle without a LOCKED mismatch.
- rx_dv held high for several cycles is treated as one byte per cycle. The upstream receiver must strobe for exactly one cycle.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding constants ST_HUNT=1'b0 and ST_LOCKED=1'b1;
  - the default baud/clock constants (CLK_HZ=50000000);
  - the sequence step constant SEQ_INC=8'd1, shared with the transmit driver.
- One natural sub-module: sat_counter (parameter W; inputs inc and clr; output q; clr has priority; holds at all-ones). It is instantiated twice, for good_cnt and err_cnt.

Test Plan:
- Reset, then the sequence 0x05,0x06,0x07 → locked=1 after the first byte; good_cnt=2, err_cnt=0, expected=0x08.
- Lock on 0xFE, then 0xFF,0x00,0x01 → wrap accepted: good_cnt=3, expected=0x02, err_pulse never asserted.
- Locked at expected=0x10; send 0x10,0xAA,0x12 → err_cnt=1 with a single err_pulse on 0xAA, good_cnt=2, locked stays 1.
- LOSS_THRESH=4; send 4 consecutive wrong bytes → err_cnt=4, lost_lock=1, locked=0. The next byte 0x30 relocks with expected=0x31.
- TIMEOUT_CYCLES=100; lock, then idle 99 cycles → timeout=1, locked=0. Repeat with rx_dv on cycle 99 → no timeout.
- clr_stats asserted in the same cycle as a matching rx_dv → good_cnt=0, expected advanced. Also: rst asserted mid-stream → all outputs return to 0, HUNT.
